// File: rtl/adc_capture_pkg.sv
// Shared types and tdata formatting for the ADC capture path.
// Optional macro ADC_TWOS_COMP_EN: emit samples as sign-extended two's complement.
package adc_capture_pkg;

  localparam int TDATA_W = 32;
  localparam int OTR_BIT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Offset binary minus half scale is the two's-complement value; 16-bit wrap gives the sign extension.
  function automatic logic [TDATA_W-1:0] format_tdata(input logic [15:0] sample,
                                                      input logic        otr,
                                                      input int          ndata);
    logic [15:0]        mask;
    logic [15:0]        s;
    logic [TDATA_W-1:0] word;
    mask = (16'd1 << ndata) - 16'd1;
    s    = sample & mask;
`ifdef ADC_TWOS_COMP_EN
    s    = s - (16'd1 << (ndata - 1));
`else
    s    = s | 16'd0;
`endif
    word          = {TDATA_W{1'b0}};
    word[15:0]    = s;
    word[OTR_BIT] = otr;
    return word;
  endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Show-ahead synchronous FIFO: dout is the head entry whenever not empty, zero otherwise.
module adc_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == {CNTW{1'b0}});
  assign full    = (count == CNTW'(DEPTH));
  assign dout    = empty ? {WIDTH{1'b0}} : mem[rd_ptr];

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CNTW{1'b0}};
    end else if (flush) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CNTW{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_axis.sv
// Parallel-ADC capture: sample-clock divider, warm-up discard, FIFO, AXI-Stream master.
// Optional macro ADC_TWOS_COMP_EN selects two's-complement tdata (applied at FIFO write).
module adc_capture_axis
  import adc_capture_pkg::*;
#(
  parameter int NDATA      = 12,
  parameter int CLK_DIV    = 4,
  parameter int PIPE_LAT   = 7,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NDATA-1:0]   adc_data,
  input  logic               adc_otr,
  output logic               adc_clk,
  output logic               m_axis_data_tvalid,
  input  logic               m_axis_data_tready,
  output logic [TDATA_W-1:0] m_axis_data_tdata,
  output logic               overflow
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int WW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2);
  localparam logic [WW-1:0] WARM_LAST = WW'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

  state_t                  state;
  state_t                  state_next;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_next;
  logic [WW-1:0]           warm_cnt;
  logic [NDATA-1:0]        din_q;
  logic                    otr_q;
  logic                    cap;
  logic                    push;
  logic                    pop;
  logic                    flush;
  logic                    warm_inc;
  logic                    adc_clk_r;
  logic                    overflow_r;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [TDATA_W-1:0]      fifo_din;

  // Capture at the end of the low phase, when the ADC output has settled.
  assign cap                = (state != IDLE) && (cnt == CNT_LAST);
  assign pop                = m_axis_data_tready && !fifo_empty;
  assign fifo_din           = format_tdata(16'(din_q), otr_q, NDATA);
  assign adc_clk            = adc_clk_r;
  assign overflow           = overflow_r;
  assign m_axis_data_tvalid = (fifo_count != '0);

  // Input registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= {NDATA{1'b0}};
      otr_q <= 1'b0;
    end else begin
      din_q <= adc_data;
      otr_q <= adc_otr;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = (PIPE_LAT == 0) ? RUN : WARMUP;
        else        state_next = IDLE;
      end
      WARMUP: begin
        if (!enable)                          state_next = IDLE;
        else if (cap && warm_cnt == WARM_LAST) state_next = RUN;
        else                                  state_next = WARMUP;
      end
      RUN: begin
        if (!enable) state_next = IDLE;
        else         state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: a sample in flight when enable drops is simply not pushed.
  always_comb begin
    push     = 1'b0;
    flush    = 1'b0;
    warm_inc = 1'b0;
    case (state)
      IDLE: begin
        push = 1'b0;
      end
      WARMUP: begin
        flush    = !enable;
        warm_inc = enable && cap;
      end
      RUN: begin
        flush = !enable;
        push  = enable && cap;
      end
      default: flush = 1'b1;
    endcase
  end

  // Divider next value
  always_comb begin
    cnt_next = cnt;
    if (state == IDLE || state_next == IDLE) cnt_next = {CW{1'b0}};
    else if (cnt == CNT_LAST)                cnt_next = {CW{1'b0}};
    else                                     cnt_next = cnt + CW'(1);
  end

  // Divider and glitch-free sample clock, aligned with cnt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= {CW{1'b0}};
      adc_clk_r <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      adc_clk_r <= (state_next != IDLE) && (cnt_next < CNT_HALF);
    end
  end

  // Warm-up capture counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               warm_cnt <= {WW{1'b0}};
    else if (state == IDLE) warm_cnt <= {WW{1'b0}};
    else if (warm_inc)      warm_cnt <= warm_cnt + WW'(1);
    else                    warm_cnt <= warm_cnt;
  end

  // Sticky drop flag, cleared when capture stops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             overflow_r <= 1'b0;
    else if (flush)                       overflow_r <= 1'b0;
    else if (push && fifo_full && !pop)   overflow_r <= 1'b1;
    else                                  overflow_r <= overflow_r;
  end

  adc_sync_fifo #(
    .WIDTH (TDATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (fifo_din),
    .dout  (m_axis_data_tdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_adc_capture_axis.sv
// Randomized bench for adc_capture_axis against a queue-based behavioural model.
module tb_adc_capture_axis;

  localparam int NDATA    = 12;
  localparam int CLK_DIV  = 4;
  localparam int PIPE_LAT = 7;
  localparam int DEPTH    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             enable = 1'b0;
  logic [NDATA-1:0] adc_data = '0;
  logic             adc_otr = 1'b0;
  logic             tready = 1'b0;
  logic             adc_clk;
  logic             tvalid;
  logic [31:0]      tdata;
  logic             overflow;

  always #5 clk = ~clk;

  adc_capture_axis #(
    .NDATA(NDATA), .CLK_DIV(CLK_DIV), .PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_data(adc_data), .adc_otr(adc_otr),
    .adc_clk(adc_clk), .m_axis_data_tvalid(tvalid), .m_axis_data_tready(tready),
    .m_axis_data_tdata(tdata), .overflow(overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word from a raw ADC code: value as the spec defines it, as 16-bit field plus otr.
  function automatic logic [31:0] expect_word(input logic [NDATA-1:0] d, input logic o);
    int v;
    v = int'(d);
`ifdef ADC_TWOS_COMP_EN
    v = v - (1 << (NDATA - 1));
`endif
    return {15'd0, o, v[15:0]};
  endfunction

  function automatic logic [31:0] ramp_word(input int n);
    return expect_word(NDATA'(n), 1'b0);
  endfunction

  // Behavioural model: phase since enable, captures seen, output queue
  logic [31:0]      m_q[$];
  bit               m_active;
  int               m_k;
  int               m_caps;
  bit               m_ovf;
  bit               m_pop;
  logic [NDATA-1:0] m_prev_data;
  logic             m_prev_otr;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_q.delete(); m_active = 0; m_k = 0; m_caps = 0; m_ovf = 0;
      m_prev_data = '0; m_prev_otr = 1'b0;
    end else begin
      m_pop = (m_q.size() != 0) && tready;
      if (!m_active) begin
        if (enable) begin m_active = 1; m_k = 0; m_caps = 0; end
      end else if (!enable) begin
        m_active = 0; m_q.delete(); m_ovf = 0;
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_k % CLK_DIV == CLK_DIV - 1) begin
          if (m_caps >= PIPE_LAT) begin
            if (m_q.size() < DEPTH) m_q.push_back(expect_word(m_prev_data, m_prev_otr));
            else m_ovf = 1;
          end
          m_caps++;
        end
        m_k++;
      end
      m_prev_data = adc_data;
      m_prev_otr  = adc_otr;
    end
  end

  // Compare process: every cycle out of reset
  logic [31:0] pop_log[$];
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("tvalid", tvalid, m_q.size() != 0);
      if (m_q.size() != 0) check("tdata", tdata, m_q[0]);
      check("overflow", overflow, m_ovf);
      check("adc_clk", adc_clk, m_active && ((m_k % CLK_DIV) < CLK_DIV / 2));
      if (tvalid && tready) pop_log.push_back(tdata);
    end
  end

  // Data driver: 0 = hold, 1 = ramp (+1 per sample period), 2 = random
  int data_mode = 0;
  int ramp_s    = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (data_mode == 1) begin
      ramp_s++;
      adc_data = NDATA'(ramp_s / CLK_DIV);
      adc_otr  = 1'b0;
    end else if (data_mode == 2) begin
      adc_data = NDATA'($urandom);
      adc_otr  = 1'($urandom);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic enable_ramp();
    data_mode = 1; ramp_s = 0; adc_data = '0; adc_otr = 1'b0; enable = 1'b1;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!tvalid && n < 200) begin tick(); n++; end
    check(name, tvalid, 1'b1);
  endtask

  task automatic wait_fill(input string name, input int lvl);
    int n;
    n = 0;
    while (m_q.size() != lvl && n < 200) begin tick(); n++; end
    check(name, n < 200, 1'b1);
  endtask

  task automatic const_word(input string name, input logic [NDATA-1:0] d, input logic o,
                            input logic [31:0] exp);
    int n;
    enable = 1'b0; tick();
    data_mode = 0; tready = 1'b1; adc_data = d; adc_otr = o; enable = 1'b1;
    wait_valid({name, "_valid"}, n);
    check(name, tdata, exp);
  endtask

  initial begin
    int n;
    int vcnt;
    bit prev_v;
    bit consec;
    repeat (3) tick();
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 32'h0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_adc_clk", adc_clk, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 100; i++) begin tick(); check("idle_adc_clk", adc_clk, 1'b0); end

    // Warm-up discard with a ramp: 7 captures dropped, then one word per period
    tready = 1'b1;
    enable_ramp();
    wait_valid("first_valid", n);
    check("warmup_latency", n, 33);
    check("first_tdata", tdata, ramp_word(7));
    vcnt = 0; prev_v = 0; consec = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (tvalid) vcnt++;
      if (tvalid && prev_v) consec = 1;
      prev_v = tvalid;
    end
    check("valid_rate", vcnt, 10);
    check("valid_single", consec, 1'b0);

    // Backpressure: fill, overflow on the ninth capture, then drain in order
    enable = 1'b0; tick();
    tready = 1'b0;
    enable_ramp();
    n = 0;
    while (!overflow && n < 200) begin tick(); n++; end
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", tdata, ramp_word(7));
    pop_log.delete();
    tready = 1'b1;
    repeat (8) tick();
    tready = 1'b0;
    check("drain_count", pop_log.size(), 8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) check("drain_order", pop_log[i], ramp_word(7 + i));

    // Disable mid-run with 5 words buffered
    wait_fill("fill5", 5);
    check("ovf_sticky", overflow, 1'b1);
    enable = 1'b0; tick();
    check("dis_tvalid", tvalid, 1'b0);
    check("dis_overflow", overflow, 1'b0);
    check("dis_adc_clk", adc_clk, 1'b0);
    tready = 1'b1;
    enable_ramp();
    wait_valid("rewarm_valid", n);
    check("rewarm_latency", n, 33);
    check("rewarm_tdata", tdata, ramp_word(7));

    // Full FIFO with pops only on capture cycles: no drops, order kept
    enable = 1'b0; tick();
    tready = 1'b0;
    enable_ramp();
    wait_fill("fill_full", DEPTH);
    pop_log.delete();
    repeat (24) begin
      tready = m_active && (m_k % CLK_DIV == CLK_DIV - 1);
      tick();
    end
    tready = 1'b0;
    check("fullpop_overflow", overflow, 1'b0);
    check("fullpop_count", pop_log.size(), 6);
    for (int i = 0; i < 6 && i < pop_log.size(); i++) check("fullpop_order", pop_log[i], ramp_word(7 + i));
    check("fullpop_head", tdata, ramp_word(13));
    check("fullpop_valid", tvalid, 1'b1);

    // Sample formatting corner codes
`ifdef ADC_TWOS_COMP_EN
    const_word("fmt_mid", 12'h800, 1'b0, 32'h00000000);
    const_word("fmt_zero", 12'h000, 1'b0, 32'h0000F800);
    const_word("fmt_max_otr", 12'hFFF, 1'b1, 32'h000107FF);
`else
    const_word("fmt_mid", 12'h800, 1'b0, 32'h00000800);
    const_word("fmt_zero", 12'h000, 1'b0, 32'h00000000);
    const_word("fmt_max_otr", 12'hFFF, 1'b1, 32'h00010FFF);
`endif

    // Random traffic with enable toggles and an asynchronous reset in the middle
    data_mode = 2;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if (i < 1500) tready = ($urandom_range(0, 3) != 0);
      else          tready = ($urandom_range(0, 3) == 0);
      if (i == 1500) begin
        #1 rst = 1'b0;
        #1;
        check("arst_tvalid", tvalid, 1'b0);
        check("arst_tdata", tdata, 32'h0);
        check("arst_overflow", overflow, 1'b0);
        check("arst_adc_clk", adc_clk, 1'b0);
        tick(); tick();
        rst = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
